sdram_test_seq: RTL and testbench

- Traffic generator and checker upstream of the SDRAM controller in the hardware test top.
- On `start`, writes a deterministic address-derived pattern to 2^TEST_ADDR_BITS consecutive words, then reads every word back and compares it with the pattern.
- Reports busy/done/pass, an error count and the first failing address, which the top drives onto LEDs.
- Talks to the controller over a valid/ready request channel and an in-order read-return channel.

---
 rtl/sdram_test_pkg.sv | 23 ++
 rtl/sdram_test_chk.sv | 51 +++++
 rtl/sdram_test_seq.sv | 184 ++++++++++++++++++
 tb/tb_sdram_test_seq.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_test_pkg.sv
// sdram_test_pkg -- shared definitions for the SDRAM test sequencer.
//   state_t  : sequencer states (IDLE, WRITE, READ, DRAIN, DONE)
//   INV_MASK : XOR mask that selects the inverted pattern
//   pattern(): address-derived test word, byte-swapped address, optionally inverted
package sdram_test_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [15:0] INV_MASK = 16'hFFFF;

    // Byte swap keeps low addresses from producing mostly-zero words,
    // so stuck-low data lines show up early in the run.
    function automatic logic [15:0] pattern(input logic [15:0] a, input logic inv);
        return {a[7:0], a[15:8]} ^ (inv ? INV_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/sdram_test_chk.sv
// sdram_test_chk -- read-back checker datapath.
// Walks chkaddr in step with returned read words, compares each against the
// expected pattern and keeps a saturating mismatch count plus the address of
// the first mismatch.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   clr             : start of a new run, clears all checker state
//   chk_en          : a returned word is to be checked this cycle
//   inv             : pattern polarity for the current pass
//   rd_data         : returned read word
//   err_count       : mismatch count, saturates at 16'hFFFF
//   first_err_addr  : address of the first mismatch, 0 if none
module sdram_test_chk
    import sdram_test_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int TEST_ADDR_BITS = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      chk_en,
    input  logic                      inv,
    input  logic [DATA_WIDTH-1:0]     rd_data,
    output logic [15:0]               err_count,
    output logic [TEST_ADDR_BITS-1:0] first_err_addr
);

    logic [TEST_ADDR_BITS-1:0] chkaddr;
    logic                      mismatch;

    assign mismatch = rd_data != DATA_WIDTH'(pattern(16'(chkaddr), inv));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            chkaddr        <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else if (chk_en) begin
            // chkaddr wraps to 0 after the last word, ready for another pass
            chkaddr <= chkaddr + TEST_ADDR_BITS'(1);
            if (mismatch) begin
                if (err_count != 16'hFFFF)
                    err_count <= err_count + 16'd1;
                if (err_count == 16'd0)
                    first_err_addr <= chkaddr;
            end
        end
    end

endmodule

// File: rtl/sdram_test_seq.sv
// sdram_test_seq -- SDRAM traffic generator and checker.
// On start, writes pattern(a) to words 0 .. 2^TEST_ADDR_BITS-1, then reads them
// all back (at most MAX_OUTSTANDING reads in flight) and checks each word.
// Optional macro SDRAM_TEST_LOOP_EN: run forever, toggling the pattern polarity
// every pass, pulsing done per pass and counting passes on loop_count.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start, invert            : run start pulse, pattern polarity (sampled on start)
//   req_valid/ready/we/addr/wdata : request channel to the controller
//   rd_valid, rd_data        : in-order read return channel
//   busy, done, pass         : run status; pass is meaningful while done
//   err_count, first_err_addr: mismatch statistics
//   proto_err                : sticky, read data arrived with no read outstanding
//   loop_count               : completed passes (loop build only)
module sdram_test_seq
    import sdram_test_pkg::*;
#(
    parameter int ADDR_DEPTH      = 24,
    parameter int DATA_WIDTH      = 16,
    parameter int TEST_ADDR_BITS  = 10,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      invert,
    output logic                      req_valid,
    input  logic                      req_ready,
    output logic                      req_we,
    output logic [ADDR_DEPTH-1:0]     req_addr,
    output logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic                      rd_valid,
    input  logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [15:0]               err_count,
    output logic [TEST_ADDR_BITS-1:0] first_err_addr,
    output logic                      proto_err
`ifdef SDRAM_TEST_LOOP_EN
   ,output logic [15:0]               loop_count
`endif
);

    localparam int            OW      = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

    state_t                    state;
    logic [TEST_ADDR_BITS-1:0] waddr;
    logic [TEST_ADDR_BITS-1:0] raddr;
    logic [OW-1:0]             outstanding;
    logic [OW-1:0]             out_next;
    logic                      inv_q;
    logic                      hs;
    logic                      rd_hs;
    logic                      in_chk;
    logic                      chk_en;
    logic                      proto_hit;
    logic                      run_start;

    // Request outputs are pure functions of registered state, so they cannot
    // move while a request is stalled; in READ, outstanding can only fall
    // before the handshake, so req_valid never drops without one.
    always_comb begin
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        case (state)
            WRITE: begin
                req_valid = 1'b1;
                req_we    = 1'b1;
                req_addr  = ADDR_DEPTH'(waddr);
                req_wdata = DATA_WIDTH'(pattern(16'(waddr), inv_q));
            end
            READ: begin
                req_valid = outstanding < MAX_OUT;
                req_addr  = ADDR_DEPTH'(raddr);
            end
            default: ;
        endcase
    end

    assign hs        = req_valid && req_ready;
    assign rd_hs     = hs && (state == READ);
    assign in_chk    = (state == READ) || (state == DRAIN);
    assign chk_en    = rd_valid && in_chk && (outstanding != '0);
    // Stray data in IDLE/DONE is ignored: it can be a leftover from a run cut
    // short by reset.
    assign proto_hit = rd_valid && !chk_en && ((state == WRITE) || in_chk);
    assign run_start = start && ((state == IDLE) || (state == DONE));
    assign pass      = done && (err_count == 16'd0) && !proto_err;

    always_comb begin
        out_next = outstanding;
        if (rd_hs && !chk_en)
            out_next = outstanding + OW'(1);
        else if (!rd_hs && chk_en)
            out_next = outstanding - OW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            waddr       <= '0;
            raddr       <= '0;
            outstanding <= '0;
            inv_q       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            proto_err   <= 1'b0;
`ifdef SDRAM_TEST_LOOP_EN
            loop_count  <= '0;
`endif
        end else begin
            outstanding <= out_next;
            if (proto_hit)
                proto_err <= 1'b1;
`ifdef SDRAM_TEST_LOOP_EN
            done <= 1'b0;
`endif
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= WRITE;
                        waddr       <= '0;
                        raddr       <= '0;
                        outstanding <= '0;
                        inv_q       <= invert;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        proto_err   <= 1'b0;
                    end
                end
                WRITE: begin
                    if (hs) begin
                        waddr <= waddr + TEST_ADDR_BITS'(1);
                        if (waddr == '1)
                            state <= READ;
                    end
                end
                READ: begin
                    if (hs) begin
                        raddr <= raddr + TEST_ADDR_BITS'(1);
                        if (raddr == '1)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // out_next covers the word checked in this very cycle
                    if (out_next == '0) begin
`ifdef SDRAM_TEST_LOOP_EN
                        // waddr/raddr/chkaddr have already wrapped to 0
                        state      <= WRITE;
                        inv_q      <= ~inv_q;
                        done       <= 1'b1;
                        loop_count <= loop_count + 16'd1;
`else
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sdram_test_chk #(
        .DATA_WIDTH     (DATA_WIDTH),
        .TEST_ADDR_BITS (TEST_ADDR_BITS)
    ) u_chk (
        .clk            (clk),
        .rst            (rst),
        .clr            (run_start),
        .chk_en         (chk_en),
        .inv            (inv_q),
        .rd_data        (rd_data),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

endmodule

// File: tb/tb_sdram_test_seq.sv
// Bench for sdram_test_seq: a controller model (random ready, fixed read
// latency, optional per-address corruption, injectable stray read data) plus
// a reference that predicts every request from the address sequence alone.
module tb_sdram_test_seq;

    localparam int AB = 4;
    localparam int N  = 16;
    localparam int MO = 2;
    localparam int AD = 24;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          invert = 1'b0;
    logic          req_ready = 1'b0;
    logic          rd_valid = 1'b0;
    logic [DW-1:0] rd_data = '0;
    logic          req_valid, req_we;
    logic [AD-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          busy, done, pass, proto_err;
    logic [15:0]   err_count;
    logic [AB-1:0] first_err_addr;
`ifdef SDRAM_TEST_LOOP_EN
    logic [15:0]   loop_count;
`endif

    int checks = 0;
    int failures = 0;

    // knobs written only by the stimulus block
    int          lat = 3;
    bit          rdy_rand = 1'b0;
    logic [15:0] corrupt_mask = '0;
    int          inject_at = -1;
    bit          run_inv = 1'b0;

    // controller / monitor state written only by the model block
    int          cyc = 0;
    int          wsince = 0, rsince = 0;
    int          wr_err = 0, rd_err = 0, stab_err = 0;
    int          mon_out = 0, max_out = 0, done_pulses = 0;
    logic [15:0] mem  [N];
    logic [15:0] wlog [N];
    int          q_due[$];
    logic [15:0] q_data[$];
    bit          prev_stall = 1'b0, prev_done = 1'b0, prev_we = 1'b0;
    logic [AD-1:0] prev_addr = '0;
    logic [DW-1:0] prev_wdata = '0;

    sdram_test_seq #(
        .ADDR_DEPTH(AD), .DATA_WIDTH(DW), .TEST_ADDR_BITS(AB), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .invert(invert),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr), .proto_err(proto_err)
`ifdef SDRAM_TEST_LOOP_EN
       ,.loop_count(loop_count)
`endif
    );

    always #5 clk = ~clk;

    // Expected word: address bytes swapped, optionally complemented.
    function automatic logic [15:0] ref_p(input int a, input bit inv);
        int s;
        s = ((a % 256) * 256) + ((a / 256) % 256);
        return 16'(s) ^ (inv ? 16'hFFFF : 16'h0000);
    endfunction

    // Inputs change and handshakes are judged on the falling edge; the DUT
    // acts on them at the following rising edge.
    always @(negedge clk) begin
        int a;
        cyc++;
        req_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        rd_valid  = 1'b0;
        rd_data   = '0;
        if (q_due.size() > 0 && q_due[0] <= cyc) begin
            rd_valid = 1'b1;
            rd_data  = q_data[0];
            void'(q_due.pop_front());
            void'(q_data.pop_front());
            mon_out--;
        end else if (cyc == inject_at) begin
            rd_valid = 1'b1;
            rd_data  = 16'h5A5A;
        end
        if (done && !prev_done) done_pulses++;
        prev_done = done;
        if (start && !busy) begin
            wsince = 0;
            rsince = 0;
        end
        if (prev_stall && (!req_valid || req_we != prev_we || req_addr != prev_addr ||
                           req_wdata != prev_wdata))
            stab_err++;
        prev_stall = req_valid && !req_ready;
        prev_we    = req_we;
        prev_addr  = req_addr;
        prev_wdata = req_wdata;
        if (req_valid && req_ready) begin
            a = int'(req_addr[AB-1:0]);
            if (req_we) begin
                if (req_addr != AD'(wsince % N) ||
                    req_wdata != ref_p(wsince % N, run_inv ^ (((wsince / N) % 2) == 1)))
                    wr_err++;
                mem[a]  = req_wdata;
                wlog[a] = req_wdata;
                wsince++;
            end else begin
                if (req_addr != AD'(rsince % N)) rd_err++;
                q_due.push_back(cyc + lat);
                q_data.push_back(mem[a] ^ (corrupt_mask[a] ? 16'h0001 : 16'h0000));
                rsince++;
                mon_out++;
                if (mon_out > max_out) max_out = mon_out;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic kick(input bit inv);
        run_inv = inv;
        invert  = inv;
        start   = 1'b1;
        step(1);
        start   = 1'b0;
        invert  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            step(1);
            n++;
        end
        chk({tag, "_finished"}, 32'(done), 1);
    endtask

    initial begin
        logic [15:0] mask;
        int          exp_err, exp_first, n;
        bit          inv;

        rst = 1'b1;
        step(3);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_err", 32'(err_count), 0);
        chk("rst_first", 32'(first_err_addr), 0);
        chk("rst_proto", 32'(proto_err), 0);
        chk("rst_req_valid", 32'(req_valid), 0);
        rst = 1'b0;
        step(2);

`ifdef SDRAM_TEST_LOOP_EN
        chk("rst_loop_count", 32'(loop_count), 0);
        kick(1'b0);
        n = 0;
        while (loop_count != 16'd3 && n < 5000) begin
            step(1);
            n++;
        end
        step(1);
        chk("loop_count", 32'(loop_count), 3);
        chk("loop_done_pulses", 32'(done_pulses), 3);
        chk("loop_busy", 32'(busy), 1);
        chk("loop_done_low", 32'(done), 0);
        chk("loop_writes_seen", 32'(wsince >= 3 * N), 1);
        chk("loop_write_patterns", 32'(wr_err), 0);
        chk("loop_read_addrs", 32'(rd_err), 0);
        chk("loop_err", 32'(err_count), 0);
        chk("loop_proto", 32'(proto_err), 0);
`else
        // basic run, ideal controller
        lat = 3; rdy_rand = 1'b0; corrupt_mask = '0; run_inv = 1'b0;
        invert = 1'b0;
        start  = 1'b1;
        chk("start_cycle_valid", 32'(req_valid), 0);
        step(1);
        start = 1'b0;
        chk("first_valid", 32'(req_valid), 1);
        chk("first_we", 32'(req_we), 1);
        chk("first_addr", 32'(req_addr), 0);
        chk("first_wdata", 32'(req_wdata), 32'(ref_p(0, 1'b0)));
        chk("busy_run", 32'(busy), 1);
        wait_done("basic");
        chk("basic_pass", 32'(pass), 1);
        chk("basic_err", 32'(err_count), 0);
        chk("basic_busy", 32'(busy), 0);
        chk("basic_writes", 32'(wsince), N);
        chk("basic_reads", 32'(rsince), N);
        chk("basic_addr1_data", 32'(wlog[1]), 32'h0100);
        chk("basic_write_patterns", 32'(wr_err), 0);
        chk("basic_read_addrs", 32'(rd_err), 0);
        step(5);
        chk("done_held", 32'(done), 1);
        // stray read data in DONE is ignored
        inject_at = cyc + 1;
        step(4);
        chk("done_stray_proto", 32'(proto_err), 0);
        chk("done_stray_pass", 32'(pass), 1);

        // single corrupted word at address 5
        corrupt_mask = 16'h0020;
        kick(1'b0);
        wait_done("corrupt5");
        chk("c5_err", 32'(err_count), 1);
        chk("c5_first", 32'(first_err_addr), 5);
        chk("c5_pass", 32'(pass), 0);

        // random corruption set, random polarity
        for (int r = 0; r < 3; r++) begin
            mask = 16'($urandom_range(1, 16'hFFFF));
            inv  = 1'($urandom_range(0, 1));
            exp_err = 0;
            exp_first = 0;
            for (int i = N - 1; i >= 0; i--) begin
                if (mask[i]) begin
                    exp_err++;
                    exp_first = i;
                end
            end
            corrupt_mask = mask;
            kick(inv);
            wait_done("rand_corrupt");
            chk("rc_err", 32'(err_count), 32'(exp_err));
            chk("rc_first", 32'(first_err_addr), 32'(exp_first));
            chk("rc_pass", 32'(pass), 0);
            chk("rc_write_patterns", 32'(wr_err), 0);
        end

        // random ready, long latency, plus a start while busy
        corrupt_mask = '0; rdy_rand = 1'b1; lat = 7;
        kick(1'($urandom_range(0, 1)));
        step(6);
        invert = ~run_inv;
        start  = 1'b1;
        step(1);
        start  = 1'b0;
        invert = 1'b0;
        wait_done("slow");
        chk("slow_pass", 32'(pass), 1);
        chk("slow_max_out", 32'(max_out <= MO), 1);
        chk("slow_stable", 32'(stab_err), 0);
        chk("slow_write_patterns", 32'(wr_err), 0);
        chk("slow_read_addrs", 32'(rd_err), 0);
        chk("slow_writes", 32'(wsince), N);

        // stray read data during WRITE
        rdy_rand = 1'b0; lat = 3;
        kick(1'b0);
        step(2);
        inject_at = cyc + 1;
        step(1);
        chk("write_stray_proto", 32'(proto_err), 1);
        wait_done("proto");
        chk("proto_pass", 32'(pass), 0);
        chk("proto_err_count", 32'(err_count), 0);

        // reset in the middle of READ at raddr 9
        kick(1'b0);
        n = 0;
        while (rsince != 9 && n < 500) begin
            step(1);
            n++;
        end
        chk("reach_raddr9", 32'(rsince), 9);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_req", {req_valid, req_we, 6'd0, req_addr}, 0);
        chk("midrst_wdata", 32'(req_wdata), 0);
        chk("midrst_err", {err_count, 12'd0, first_err_addr}, 0);
        step(10);
        chk("midrst_stale_proto", 32'(proto_err), 0);
        kick(1'b1);
        chk("inv_first_wdata", 32'(req_wdata), 32'hFFFF);
        wait_done("after_rst");
        chk("after_rst_pass", 32'(pass), 1);
        chk("after_rst_write_patterns", 32'(wr_err), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
